// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared fetch/decode types and constants
package pipe_pkg;

  localparam int PIPE_W = 32;

  typedef struct packed {
    logic [PIPE_W-1:0] pc;
    logic [PIPE_W-1:0] instr;
  } if_entry_t;

  localparam logic [31:0] NOP_INSTR = 32'h0;
  localparam int          PC_STEP   = 4;

  // Fill level of the fetch queue, derived from the entry count
  typedef enum logic [1:0] {
    FILL_EMPTY,
    FILL_PARTIAL,
    FILL_FULL
  } fill_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] value
);

  always_ff @(posedge clk) begin
    if (clr) begin
      value <= '0;
    end else if (inc && (value != {CNT_W{1'b1}})) begin
      value <= value + CNT_W'(1);
    end
  end

endmodule

// File: rtl/if_id_buffer.sv
// rtl/if_id_buffer.sv - fetch-to-decode queue with PC back-pressure, flush and stall/flush statistics
module if_id_buffer
  import pipe_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           PCVal,
  input  logic [WIDTH-1:0]           instr,
  input  logic                       fetchValid,
  input  logic                       decodeReady,
  input  logic                       flush,
  output logic                       holdPC,
  output logic                       IDvalid,
  output logic [WIDTH-1:0]           IDinstr,
  output logic [WIDTH-1:0]           IDpc,
  output logic [WIDTH-1:0]           IDpc4,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [CNT_W-1:0]           stallCount,
  output logic [CNT_W-1:0]           flushCount
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] pc_mem    [DEPTH];
  logic [WIDTH-1:0] instr_mem [DEPTH];

  logic [PW-1:0] wr_ptr, wr_ptr_nx;
  logic [PW-1:0] rd_ptr, rd_ptr_nx;
  logic [CW-1:0] count,  count_nx;
  fill_t         level;
  logic          push, pop;

  always_comb begin
    level = FILL_EMPTY;
    if (count == CW'(DEPTH)) begin
      level = FILL_FULL;
    end else if (count != '0) begin
      level = FILL_PARTIAL;
    end
  end

  // A full queue refuses the push even when a pop frees a slot the same cycle
  assign push = fetchValid && (level != FILL_FULL) && !flush;
  assign pop  = (level != FILL_EMPTY) && decodeReady && !flush;

  always_comb begin
    wr_ptr_nx = wr_ptr;
    rd_ptr_nx = rd_ptr;
    count_nx  = count;
    if (flush) begin
      wr_ptr_nx = '0;
      rd_ptr_nx = '0;
      count_nx  = '0;
    end else begin
      if (push) wr_ptr_nx = wr_ptr + PW'(1);
      if (pop)  rd_ptr_nx = rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count_nx = count + CW'(1);
        2'b01:   count_nx = count - CW'(1);
        default: count_nx = count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr_nx;
      rd_ptr <= rd_ptr_nx;
      count  <= count_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      pc_mem[wr_ptr]    <= PCVal;
      instr_mem[wr_ptr] <= instr;
    end
  end

  assign holdPC    = (level == FILL_FULL);
  assign IDvalid   = (level != FILL_EMPTY);
  assign IDinstr   = IDvalid ? instr_mem[rd_ptr] : WIDTH'(NOP_INSTR);
  assign IDpc      = IDvalid ? pc_mem[rd_ptr] : '0;
  assign IDpc4     = IDvalid ? (pc_mem[rd_ptr] + WIDTH'(PC_STEP)) : '0;
  assign occupancy = count;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (holdPC),
    .value (stallCount)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (flush),
    .value (flushCount)
  );

endmodule
